// File: rtl/db_fsm_multi.sv
// rtl/db_fsm_multi.sv - multi-channel switch debouncer with shared sample tick and edge pulses
module db_fsm_multi #(
    parameter int CH     = 4,
    parameter int TICK_N = 19,
    parameter int STABLE = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic          m_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    // Tick count at which a WAIT state is considered stable.
    localparam logic [3:0] LAST = 4'(STABLE - 1);

    logic [TICK_N-1:0] tick_cnt;
    logic [CH-1:0]     s1;
    logic [CH-1:0]     s;
    logic [CH-1:0]     lvl_d;
    state_t            state    [CH];
    state_t            state_nx [CH];
    logic [3:0]        cnt      [CH];
    logic [3:0]        cnt_nx   [CH];

    // Free-running sample-tick counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_N'(1);
        end
    end

    assign m_tick = (tick_cnt == '1);

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= sw;
            s  <= s1;
        end
    end

    // Per-channel state and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= ZERO;
                cnt[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
        end
    end

    // Next-state logic; an input mismatch in a WAIT state wins over a tick.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            case (state[i])
                ZERO: begin
                    if (s[i]) begin
                        state_nx[i] = WAIT1;
                        cnt_nx[i]   = 4'd0;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_nx[i] = ZERO;
                    end else if (m_tick && (cnt[i] == LAST)) begin
                        state_nx[i] = ONE;
                    end else if (m_tick) begin
                        cnt_nx[i] = cnt[i] + 4'd1;
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_nx[i] = WAIT0;
                        cnt_nx[i]   = 4'd0;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_nx[i] = ONE;
                    end else if (m_tick && (cnt[i] == LAST)) begin
                        state_nx[i] = ZERO;
                    end else if (m_tick) begin
                        cnt_nx[i] = cnt[i] + 4'd1;
                    end
                end
                default: begin
                    state_nx[i] = ZERO;
                    cnt_nx[i]   = 4'd0;
                end
            endcase
        end
    end

    // Clean level decoded from the registered state only, so it cannot glitch.
    always_comb begin
        db_level = '0;
        for (int i = 0; i < CH; i++) begin
            db_level[i] = (state[i] == ONE) || (state[i] == WAIT0);
        end
    end

    // Previous-cycle level; clears on reset so reset release makes no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_d <= '0;
        end else begin
            lvl_d <= db_level;
        end
    end

    assign db_rise = db_level & ~lvl_d;
    assign db_fall = ~db_level & lvl_d;

endmodule

// File: tb/tb_db_fsm_multi.sv
// tb/tb_db_fsm_multi.sv - scoreboard bench for db_fsm_multi (STABLE=3 and STABLE=1 instances)
module tb_db_fsm_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'd0;
    logic [3:0] sw1 = 4'd0;
    logic [3:0] db_level, db_rise, db_fall;
    logic [3:0] db_level1, db_rise1, db_fall1;
    logic       m_tick, m_tick1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int chan;
        int rise;
        int cyc;
    } ev_t;

    ev_t q[$];

    db_fsm_multi #(.CH(4), .TICK_N(3), .STABLE(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall),
        .m_tick   (m_tick)
    );

    db_fsm_multi #(.CH(4), .TICK_N(3), .STABLE(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw1),
        .db_level (db_level1),
        .db_rise  (db_rise1),
        .db_fall  (db_fall1),
        .m_tick   (m_tick1)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    // Cycle in which the new level first appears for an sw edge driven when cyc==c.
    function automatic int exp_cycle(input int c, input int stable);
        int n;
        n = 0;
        for (int k = c + 3; k < c + 200; k++) begin
            if (k % 8 == 7) begin
                n++;
                if (n == stable) return k + 1;
            end
        end
        return -1;
    endfunction

    task automatic push_ev(input int chan, input int rise, input int when);
        ev_t e;
        e.chan = chan;
        e.rise = rise;
        e.cyc  = when;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    // Output monitor: tick timing and every edge pulse against the scoreboard.
    always @(negedge clk) begin
        logic [7:0] rise_all;
        logic [7:0] fall_all;
        logic [7:0] lvl_all;
        ev_t e;
        if (!reset) begin
            rise_all = {db_rise1, db_rise};
            fall_all = {db_fall1, db_fall};
            lvl_all  = {db_level1, db_level};
            check("m_tick", int'(m_tick), int'(cyc % 8 == 7));
            for (int i = 0; i < 8; i++) begin
                if (rise_all[i] || fall_all[i]) begin
                    if (q.size() == 0) begin
                        check("unexpected_pulse", i, -1);
                    end else begin
                        e = q.pop_front();
                        check("ev_chan", i, e.chan);
                        check("ev_kind", int'(rise_all[i]), e.rise);
                        check("ev_both", int'(rise_all[i] & fall_all[i]), 0);
                        check("ev_cycle", cyc, e.cyc);
                        check("ev_level", int'(lvl_all[i]), e.rise);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_level", int'(db_level), 0);
        check("rst_rise", int'(db_rise), 0);
        check("rst_fall", int'(db_fall), 0);
        check("rst_tick", int'(m_tick), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_level", int'(db_level), 0);

        // Clean rise on channel 0
        c = cyc;
        sw[0] = 1'b1;
        push_ev(0, 1, exp_cycle(c, 3));
        wait_drain(60);
        check("s2_level", int'(db_level), 4'b0001);

        // Channel 1 rise with a one-cycle drop before it settles
        c = cyc;
        sw[1] = 1'b1;
        repeat (5) @(negedge clk);
        d = cyc;
        sw[1] = 1'b0;
        @(negedge clk);
        sw[1] = 1'b1;
        push_ev(1, 1, exp_cycle(d + 1, 3));
        wait_drain(60);
        check("s3_level", int'(db_level), 4'b0011);

        // Channel 2: settle high, glitch low every 5 cycles, then hold low
        c = cyc;
        sw[2] = 1'b1;
        push_ev(2, 1, exp_cycle(c, 3));
        wait_drain(60);
        for (int g = 0; g < 8; g++) begin
            repeat (4) @(negedge clk);
            sw[2] = 1'b0;
            @(negedge clk);
            sw[2] = 1'b1;
        end
        check("s4_glitch_level", int'(db_level), 4'b0111);
        repeat (2) @(negedge clk);
        c = cyc;
        sw[2] = 1'b0;
        push_ev(2, 0, exp_cycle(c, 3));
        wait_drain(60);
        check("s4_level", int'(db_level), 4'b0011);

        // Clear, then all four channels rise together
        c = cyc;
        sw = 4'b0000;
        push_ev(0, 0, exp_cycle(c, 3));
        push_ev(1, 0, exp_cycle(c, 3));
        wait_drain(60);
        repeat (3) @(negedge clk);
        c = cyc;
        sw = 4'b1111;
        for (int i = 0; i < 4; i++) push_ev(i, 1, exp_cycle(c, 3));
        wait_drain(60);
        check("s5_level", int'(db_level), 4'b1111);

        // Reset while channel 0 is in WAIT0
        sw[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("s6_wait0_level", int'(db_level[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("s6_async_level", int'(db_level), 0);
        check("s6_async_fall", int'(db_fall), 0);
        check("s6_async_rise", int'(db_rise), 0);
        check("s6_async_tick", int'(m_tick), 0);
        sw = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        check("s6_post_level", int'(db_level), 0);

        // STABLE=1 instance: rise on the first tick after WAIT1 entry
        c = cyc;
        sw1[0] = 1'b1;
        push_ev(4, 1, exp_cycle(c, 1));
        wait_drain(40);
        check("s6_stable1_level", int'(db_level1), 4'b0001);

        repeat (20) @(negedge clk);
        check("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
